// File: rtl/stream_demultiplexer_pkg.sv
// Shared constants, channel state encoding and select-decode helper for the
// stream demultiplexer slice.
//   DATA_W : width of one data beat
//   SEL_W  : select width, N_OUT = 2**SEL_W channels
//   CNT_W  : width of each per-channel transfer counter
// Optional feature macro: DEMUX_COUNT_EN (per-channel drain counters).
package stream_demultiplexer_pkg;

  localparam int unsigned DATA_W  = 2;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned N_OUT   = 1 << SEL_W;
  localparam int unsigned CNT_W   = 8;

  // Flat bus widths, also used by the bench when slicing channel fields.
  localparam int unsigned DATA_BUS_W = N_OUT * DATA_W;
  localparam int unsigned CNT_BUS_W  = N_OUT * CNT_W;

  // Channel state equals out_valid of that channel.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  // One-hot decode of a channel select.
  function automatic logic [N_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return N_OUT'(1) << sel;
  endfunction

endpackage

// File: rtl/stream_demultiplexer_if.sv
// Stream demultiplexer bus: one input stream and N_OUT output channels.
//   in_valid/in_ready/in_data/in_sel : input beat handshake and destination
//   out_valid/out_ready              : per-channel handshake
//   out_data                         : channel k at [k*DATA_W +: DATA_W]
//   out_count                        : channel k at [k*CNT_W  +: CNT_W]
// master = source/sink side, slave = demultiplexer side.
interface stream_demultiplexer_if;
  import stream_demultiplexer_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [SEL_W-1:0]      in_sel;
  logic [N_OUT-1:0]      out_valid;
  logic [N_OUT-1:0]      out_ready;
  logic [DATA_BUS_W-1:0] out_data;
  logic [CNT_BUS_W-1:0]  out_count;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/stream_demultiplexer_slot.sv
// demux_slot: one-entry holding register for a single output channel, with its
// EMPTY/FULL state machine and, when DEMUX_COUNT_EN is defined, a wrapping
// drain counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : accepted input beat addressed to this channel
//   in_data    : beat to capture on load
//   out_ready  : downstream ready
//   out_valid  : holding register full
//   out_data   : held beat
//   out_count  : completed drains (zero without DEMUX_COUNT_EN)
module demux_slot
  import stream_demultiplexer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic              drain_c;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Next state; a load while full only happens when the slot drains the same
  // cycle, so the slot stays FULL with the new beat and no bubble.
  always_comb begin
    state_d = state_q;
    drain_c = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (load) state_d = ST_FULL;
      end
      ST_FULL: begin
        drain_c = out_ready;
        if (load)           state_d = ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Holding register; stable while full and stalled because load is gated upstream.
  always_ff @(posedge clk) begin
    if (reset)     data_q <= '0;
    else if (load) data_q <= in_data;
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] count_q;

  // Drain counter, wraps modulo 2**CNT_W.
  always_ff @(posedge clk) begin
    if (reset)        count_q <= '0;
    else if (drain_c) count_q <= count_q + CNT_W'(1);
  end

  assign out_count = count_q;
`else
  logic unused_drain;
  assign unused_drain = drain_c;
  assign out_count    = '0;
`endif

endmodule

// File: rtl/stream_demultiplexer.sv
// stream_demultiplexer: routes one DATA_W-bit stream to one of N_OUT channels
// selected per beat by in_sel. Each channel is an independent one-entry slot,
// so a stalled channel blocks only beats addressed to it.
//   clk, reset : clock, synchronous active-high reset
//   s          : stream_demultiplexer_if.slave (input stream, output channels)
// Optional feature macro: DEMUX_COUNT_EN (per-channel drain counters on out_count).
module stream_demultiplexer
  import stream_demultiplexer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  stream_demultiplexer_if.slave s
);

  logic [N_OUT-1:0]      valid_w;
  logic [DATA_BUS_W-1:0] data_w;
  logic [CNT_BUS_W-1:0]  count_w;
  logic [N_OUT-1:0]      load_c;
  logic                  in_ready_c;

  // Input is ready when the addressed slot is empty or draining this cycle.
  always_comb begin
    in_ready_c = ~valid_w[s.in_sel] | s.out_ready[s.in_sel];
  end

  // Select decode; at most one slot loads per cycle.
  always_comb begin
    load_c = '0;
    if (s.in_valid && in_ready_c) load_c = sel_onehot(s.in_sel);
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load_c[k]),
      .in_data   (s.in_data),
      .out_ready (s.out_ready[k]),
      .out_valid (valid_w[k]),
      .out_data  (data_w[k*DATA_W +: DATA_W]),
      .out_count (count_w[k*CNT_W +: CNT_W])
    );
  end

  assign s.in_ready  = in_ready_c;
  assign s.out_valid = valid_w;
  assign s.out_data  = data_w;
  assign s.out_count = count_w;

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Directed self-checking bench for stream_demultiplexer: reset, routing,
// per-channel stall, drain+load in one cycle, mid-operation reset and the
// optional drain counters (DEMUX_COUNT_EN).
module tb_stream_demultiplexer;
  import stream_demultiplexer_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  stream_demultiplexer_if dif ();

  stream_demultiplexer dut (
    .clk   (clk),
    .reset (reset),
    .s     (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt_of(input logic [CNT_BUS_W-1:0] bus, input int k);
    return 32'(bus[k*CNT_W +: CNT_W]);
  endfunction

  logic [DATA_W-1:0] vals [4];
  logic [31:0]       exp_cnt;

  initial begin
    total = 0;
    bad   = 0;
    vals[0] = 2'b01; vals[1] = 2'b10; vals[2] = 2'b11; vals[3] = 2'b00;

    // 1. Reset held two cycles with in_valid high: nothing loads.
    reset         = 1'b1;
    dif.in_valid  = 1'b1;
    dif.in_data   = 2'b11;
    dif.in_sel    = 2'd0;
    dif.out_ready = 4'b0000;
    step();
    step();
    check("rst_valid", 32'(dif.out_valid), 32'h0);
    check("rst_data",  32'(dif.out_data),  32'h0);
    check("rst_count", 32'(dif.out_count), 32'h0);
    reset        = 1'b0;
    dif.in_valid = 1'b0;
    #1;
    check("rst_in_ready", 32'(dif.in_ready), 32'h1);

    // 2. Back-to-back routing to every channel with all sinks ready.
    dif.out_ready = 4'b1111;
    dif.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dif.in_sel  = 2'(i);
      dif.in_data = vals[i];
      #1;
      check($sformatf("route_in_ready%0d", i), 32'(dif.in_ready), 32'h1);
      step();
      check($sformatf("route_valid%0d", i), 32'(dif.out_valid), 32'(4'b0001 << i));
      check($sformatf("route_data%0d", i), 32'(dif.out_data[i*DATA_W +: DATA_W]), 32'(vals[i]));
    end
    dif.in_valid = 1'b0;
    step();
    check("route_drained", 32'(dif.out_valid), 32'h0);

    // 3. Channel 2 stalled: blocks only beats addressed to it.
    dif.out_ready = 4'b1011;
    dif.in_valid  = 1'b1;
    dif.in_sel    = 2'd2;
    dif.in_data   = 2'b11;
    step();
    check("stall_valid", 32'(dif.out_valid), 32'b0100);
    check("stall_data2", 32'(dif.out_data[5:4]), 32'b11);
    dif.in_data = 2'b01;
    #1;
    check("stall_in_ready_sel2", 32'(dif.in_ready), 32'h0);
    step();
    check("stall_hold2", 32'(dif.out_data[5:4]), 32'b11);
    dif.in_sel  = 2'd1;
    dif.in_data = 2'b10;
    #1;
    check("stall_in_ready_sel1", 32'(dif.in_ready), 32'h1);
    step();
    check("stall_other_valid", 32'(dif.out_valid), 32'b0110);
    check("stall_data1", 32'(dif.out_data[3:2]), 32'b10);
    check("stall_hold2b", 32'(dif.out_data[5:4]), 32'b11);
    dif.in_valid = 1'b0;
    step();
    check("stall_ch1_drained", 32'(dif.out_valid), 32'b0100);
    dif.out_ready = 4'b1111;
    step();
    check("stall_released", 32'(dif.out_valid), 32'h0);

    // 4. Drain and reload channel 0 in the same cycle: no bubble.
    dif.out_ready = 4'b0000;
    dif.in_valid  = 1'b1;
    dif.in_sel    = 2'd0;
    dif.in_data   = 2'b01;
    step();
    check("pass_first", 32'(dif.out_data[1:0]), 32'b01);
    dif.out_ready = 4'b0001;
    dif.in_data   = 2'b10;
    #1;
    check("pass_in_ready", 32'(dif.in_ready), 32'h1);
    step();
    check("pass_valid", 32'(dif.out_valid), 32'b0001);
    check("pass_data",  32'(dif.out_data[1:0]), 32'b10);
    dif.in_valid = 1'b0;
    step();
    check("pass_drained", 32'(dif.out_valid), 32'h0);

    // 5. Reset with channels 1 and 3 full and stalled discards them.
    dif.out_ready = 4'b0000;
    dif.in_valid  = 1'b1;
    dif.in_sel    = 2'd1;
    dif.in_data   = 2'b10;
    step();
    dif.in_sel  = 2'd3;
    dif.in_data = 2'b01;
    step();
    check("mid_full", 32'(dif.out_valid), 32'b1010);
    dif.in_valid = 1'b0;
    reset        = 1'b1;
    step();
    check("mid_rst_valid", 32'(dif.out_valid), 32'h0);
    check("mid_rst_data",  32'(dif.out_data),  32'h0);
    check("mid_rst_count", 32'(dif.out_count), 32'h0);
    reset = 1'b0;

    // 6. 257 drains on channel 3: counter wraps to 1 when enabled.
    dif.out_ready = 4'b1111;
    dif.in_valid  = 1'b1;
    dif.in_sel    = 2'd3;
    for (int i = 0; i < 257; i++) begin
      dif.in_data = 2'(i);
      step();
    end
    check("cnt_last_data", 32'(dif.out_data[7:6]), 32'(2'(256)));
    check("cnt_256", cnt_of(dif.out_count, 3), 32'h0);
    dif.in_valid = 1'b0;
    step();
`ifdef DEMUX_COUNT_EN
    exp_cnt = 32'h1;
`else
    exp_cnt = 32'h0;
`endif
    check("cnt_ch3", cnt_of(dif.out_count, 3), exp_cnt);
    check("cnt_ch0", cnt_of(dif.out_count, 0), 32'h0);
    check("cnt_ch1", cnt_of(dif.out_count, 1), 32'h0);
    check("cnt_ch2", cnt_of(dif.out_count, 2), 32'h0);
    check("cnt_empty", 32'(dif.out_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
